// File: rtl/g76_memory_pkg.sv
// Shared definitions for the host-side memory port.
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH : widths of the memory manager CPU port
//   host_port_state_t               : request sequencer states
//   write_entry_t                   : one queued host write (address + data)
package g76_memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 17;
  localparam int unsigned MEM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    HP_IDLE,
    HP_WRITE_WAIT,
    HP_READ_WAIT
  } host_port_state_t;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data;
  } write_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and registered occupancy.
//   clock, reset          : posedge clock, active-high synchronous reset
//   push, push_data       : enqueue (ignored when full)
//   pop                   : dequeue head (ignored when empty)
//   head_data             : current head entry, valid while !empty
//   full, empty, count    : occupancy from registered state only
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/host_memory_port.sv
// Host-side initiator for the memory manager CPU port.
// Host writes are queued in a small FIFO; one host read may be pending.
// Exactly one memory request is outstanding at a time and is held until the
// manager's completion pulse. Queued writes always drain before a pending
// read is issued, so reads observe every earlier write.
//   clock, reset                 : posedge clock, synchronous active-high reset
//   hostAddress, hostWriteData   : sampled with the host strobes
//   hostWriteStrobe              : 1-cycle pulse, enqueue a write
//   hostReadStrobe               : 1-cycle pulse, request a read
//   hostReadData, hostReadValid  : read result (held) and its 1-cycle strobe
//   hostBusy                     : write queue full or a read pending
//   hostOverflow                 : sticky, a strobe was dropped
//   memoryAddress/WriteData      : held stable while a request is up
//   memoryRead/WriteRequest      : level requests to the manager
//   memoryReadData               : valid with memoryReadComplete
//   memoryRead/WriteComplete     : 1-cycle completion pulses from the manager
module host_memory_port
  import g76_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] hostAddress,
  input  logic [DATA_WIDTH-1:0] hostWriteData,
  input  logic                  hostWriteStrobe,
  input  logic                  hostReadStrobe,
  output logic [DATA_WIDTH-1:0] hostReadData,
  output logic                  hostReadValid,
  output logic                  hostBusy,
  output logic                  hostOverflow,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic                  memoryReadRequest,
  output logic                  memoryWriteRequest,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryReadComplete,
  input  logic                  memoryWriteComplete
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  host_port_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  wreq_q, wreq_d;
  logic                  rreq_q, rreq_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  read_pending_q, read_pending_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_write_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({hostAddress, hostWriteData}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    wreq_d         = wreq_q;
    rreq_d         = rreq_q;
    read_data_d    = read_data_q;
    read_valid_d   = 1'b0;
    read_pending_d = read_pending_q;
    read_addr_d    = read_addr_q;
    overflow_d     = overflow_q;
    fifo_pop       = 1'b0;

    // Acceptance uses registered occupancy only: a write strobe against a
    // full queue is dropped even when the head pops in the same cycle.
    fifo_push = hostWriteStrobe && !fifo_full;
    if (hostWriteStrobe && fifo_full) begin
      overflow_d = 1'b1;
    end

    if (hostReadStrobe) begin
      if (read_pending_q) begin
        overflow_d = 1'b1;
      end else begin
        read_pending_d = 1'b1;
        read_addr_d    = hostAddress;
      end
    end

    case (state_q)
      HP_IDLE: begin
        // Queued writes take priority so a pending read sees all earlier writes.
        if (!fifo_empty) begin
          mem_addr_d  = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
          mem_wdata_d = fifo_head[DATA_WIDTH-1:0];
          wreq_d      = 1'b1;
          state_d     = HP_WRITE_WAIT;
        end else if (read_pending_q) begin
          mem_addr_d = read_addr_q;
          rreq_d     = 1'b1;
          state_d    = HP_READ_WAIT;
        end
      end
      HP_WRITE_WAIT: begin
        if (memoryWriteComplete) begin
          wreq_d   = 1'b0;
          fifo_pop = 1'b1;
          state_d  = HP_IDLE;
        end
      end
      HP_READ_WAIT: begin
        if (memoryReadComplete) begin
          rreq_d         = 1'b0;
          read_data_d    = memoryReadData;
          read_valid_d   = 1'b1;
          read_pending_d = 1'b0;
          state_d        = HP_IDLE;
        end
      end
      default: begin
        state_d = HP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= HP_IDLE;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      wreq_q         <= 1'b0;
      rreq_q         <= 1'b0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      read_pending_q <= 1'b0;
      read_addr_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      wreq_q         <= wreq_d;
      rreq_q         <= rreq_d;
      read_data_q    <= read_data_d;
      read_valid_q   <= read_valid_d;
      read_pending_q <= read_pending_d;
      read_addr_q    <= read_addr_d;
      overflow_q     <= overflow_d;
    end
  end

  assign hostReadData       = read_data_q;
  assign hostReadValid      = read_valid_q;
  assign hostBusy           = (fifo_count == FIFO_FULL_CNT) || read_pending_q;
  assign hostOverflow       = overflow_q;
  assign memoryAddress      = mem_addr_q;
  assign memoryWriteData    = mem_wdata_q;
  assign memoryReadRequest  = rreq_q;
  assign memoryWriteRequest = wreq_q;

endmodule

// File: tb/tb_host_memory_port.sv
// Bench for host_memory_port: directed scenarios plus a randomized phase,
// with a memory-manager model and a program-order memory reference.
module tb_host_memory_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] hostAddress;
  logic [7:0]  hostWriteData;
  logic        hostWriteStrobe;
  logic        hostReadStrobe;
  logic [7:0]  hostReadData;
  logic        hostReadValid;
  logic        hostBusy;
  logic        hostOverflow;
  logic [16:0] memoryAddress;
  logic [7:0]  memoryWriteData;
  logic        memoryReadRequest;
  logic        memoryWriteRequest;
  logic [7:0]  memoryReadData;
  logic        memoryReadComplete;
  logic        memoryWriteComplete;

  host_memory_port #(
    .ADDR_WIDTH (17),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .hostAddress         (hostAddress),
    .hostWriteData       (hostWriteData),
    .hostWriteStrobe     (hostWriteStrobe),
    .hostReadStrobe      (hostReadStrobe),
    .hostReadData        (hostReadData),
    .hostReadValid       (hostReadValid),
    .hostBusy            (hostBusy),
    .hostOverflow        (hostOverflow),
    .memoryAddress       (memoryAddress),
    .memoryWriteData     (memoryWriteData),
    .memoryReadRequest   (memoryReadRequest),
    .memoryWriteRequest  (memoryWriteRequest),
    .memoryReadData      (memoryReadData),
    .memoryReadComplete  (memoryReadComplete),
    .memoryWriteComplete (memoryWriteComplete)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          w;
    logic [16:0] a;
    logic [7:0]  d;
  } op_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned valid_cnt = 0;
  logic        prev_valid = 1'b0;

  op_t         log_q[$];
  op_t         exp_w[$];
  logic [7:0]  mgr_mem [logic [16:0]];
  logic [7:0]  ref_mem [logic [16:0]];

  bit          mgr_active = 0;
  bit          mgr_is_w;
  logic [16:0] mgr_addr;
  logic [7:0]  mgr_data;
  int unsigned mgr_rem;

  localparam logic [16:0] RAND_BASE = 17'h1F000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Manager model: completes each request 3..6 cycles after it appears and
  // checks that address/data stay stable while the request is held.
  initial begin
    bit pulse_prev;
    memoryWriteComplete = 1'b0;
    memoryReadComplete  = 1'b0;
    memoryReadData      = '0;
    forever begin
      @(negedge clock);
      pulse_prev = memoryWriteComplete | memoryReadComplete;
      memoryWriteComplete = 1'b0;
      memoryReadComplete  = 1'b0;
      if (pulse_prev && !reset)
        chk("req_gap", 32'(memoryWriteRequest | memoryReadRequest), 0);
      if (mgr_active) begin
        if (mgr_is_w ? memoryWriteRequest : memoryReadRequest) begin
          chk("mgr_addr_stable", 32'(memoryAddress), 32'(mgr_addr));
          if (mgr_is_w) chk("mgr_data_stable", 32'(memoryWriteData), 32'(mgr_data));
        end
        mgr_rem--;
        if (mgr_rem == 0) begin
          mgr_active = 0;
          if (mgr_is_w) begin
            mgr_mem[mgr_addr] = mgr_data;
            memoryWriteComplete = 1'b1;
          end else begin
            memoryReadData = mgr_mem.exists(mgr_addr) ? mgr_mem[mgr_addr] : 8'h00;
            memoryReadComplete = 1'b1;
          end
        end
      end else if (!reset && !pulse_prev && (memoryWriteRequest || memoryReadRequest)) begin
        mgr_active = 1;
        mgr_is_w   = memoryWriteRequest;
        mgr_addr   = memoryAddress;
        mgr_data   = memoryWriteRequest ? memoryWriteData : 8'h00;
        mgr_rem    = $urandom_range(3, 6) - 1;
        log_q.push_back('{w: mgr_is_w, a: mgr_addr, d: mgr_data});
      end
    end
  end

  // Continuous properties: exclusive requests, single-cycle read valid.
  always @(negedge clock) begin
    if (memoryWriteRequest || memoryReadRequest)
      chk("req_mutex", 32'(memoryWriteRequest & memoryReadRequest), 0);
    if (hostReadValid) begin
      valid_cnt++;
      chk("valid_width", 32'(prev_valid), 0);
    end
    prev_valid = hostReadValid;
  end

  task automatic host_op(input logic do_w, input logic do_r, input logic [16:0] a,
                         input logic [7:0] d);
    hostAddress     = a;
    hostWriteData   = d;
    hostWriteStrobe = do_w;
    hostReadStrobe  = do_r;
    @(negedge clock);
    hostWriteStrobe = 1'b0;
    hostReadStrobe  = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned base, input string tag);
    for (int i = 0; i < 400 && valid_cnt == base; i++) @(negedge clock);
    chk(tag, valid_cnt - base, 1);
  endtask

  task automatic drain(input string tag);
    int unsigned quiet = 0;
    for (int i = 0; i < 600 && quiet < 8; i++) begin
      @(negedge clock);
      if (!memoryWriteRequest && !memoryReadRequest && !hostBusy && !mgr_active) quiet++;
      else quiet = 0;
    end
    chk(tag, quiet, 8);
  endtask

  task automatic chk_op(input string tag, input int idx, input bit w,
                        input logic [16:0] a, input logic [7:0] d);
    op_t o;
    o = '{w: ~w, a: '0, d: '0};
    if (idx < log_q.size()) o = log_q[idx];
    chk({tag, "_kind"}, 32'(o.w), 32'(w));
    chk({tag, "_addr"}, 32'(o.a), 32'(a));
    chk({tag, "_data"}, 32'(o.d), 32'(d));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdata"},    32'(hostReadData), 0);
    chk({tag, "_rvalid"},   32'(hostReadValid), 0);
    chk({tag, "_busy"},     32'(hostBusy), 0);
    chk({tag, "_overflow"}, 32'(hostOverflow), 0);
    chk({tag, "_maddr"},    32'(memoryAddress), 0);
    chk({tag, "_mwdata"},   32'(memoryWriteData), 0);
    chk({tag, "_rreq"},     32'(memoryReadRequest), 0);
    chk({tag, "_wreq"},     32'(memoryWriteRequest), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned vbase;
    int unsigned n_reads;
    int unsigned seen_reads;
    int          wi;
    logic [16:0] ra;
    logic [7:0]  rd;
    logic [7:0]  exp_rd;

    reset = 1'b1;
    hostAddress = '0; hostWriteData = '0;
    hostWriteStrobe = 1'b0; hostReadStrobe = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // 1: single write
    log_q.delete();
    vbase = valid_cnt;
    ref_mem[17'h1A2B3] = 8'h5C;
    host_op(1, 0, 17'h1A2B3, 8'h5C);
    @(negedge clock);
    chk("t1_wreq_up", 32'(memoryWriteRequest), 1);
    drain("t1_drain");
    chk("t1_nops", log_q.size(), 1);
    chk_op("t1_op0", 0, 1, 17'h1A2B3, 8'h5C);
    chk("t1_no_valid", valid_cnt - vbase, 0);

    // 4: second read strobe while first pending is dropped
    log_q.delete();
    vbase = valid_cnt;
    host_op(0, 1, 17'h1A2B3, 8'h00);
    chk("t4_busy_pending", 32'(hostBusy), 1);
    chk("t4_ovf_before", 32'(hostOverflow), 0);
    host_op(0, 1, 17'h00777, 8'h00);
    chk("t4_ovf_after", 32'(hostOverflow), 1);
    wait_valid(vbase, "t4_valid");
    chk("t4_rdata", 32'(hostReadData), 32'(ref_mem[17'h1A2B3]));
    drain("t4_drain");
    chk("t4_nops", log_q.size(), 1);
    chk_op("t4_op0", 0, 0, 17'h1A2B3, 8'h00);
    chk("t4_nvalid", valid_cnt - vbase, 1);

    do_reset();
    chk_reset_state("reset2");

    // 2: fill the queue, fifth strobe dropped
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      ref_mem[17'h00100 + 17'(i)] = 8'hA0 + 8'(i);
      host_op(1, 0, 17'h00100 + 17'(i), 8'hA0 + 8'(i));
    end
    chk("t2_busy_full", 32'(hostBusy), 1);
    chk("t2_ovf_before", 32'(hostOverflow), 0);
    host_op(1, 0, 17'h00104, 8'hEE);
    chk("t2_ovf_after", 32'(hostOverflow), 1);
    drain("t2_drain");
    chk("t2_nops", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_op("t2_op", i, 1, 17'h00100 + 17'(i), 8'hA0 + 8'(i));

    // 3: W, W+R in the same cycle; read must follow both writes
    log_q.delete();
    vbase = valid_cnt;
    ref_mem[17'h00123] = 8'h11;
    host_op(1, 0, 17'h00123, 8'h11);
    ref_mem[17'h00010] = 8'h77;
    host_op(1, 1, 17'h00010, 8'h77);
    wait_valid(vbase, "t3_valid");
    chk("t3_rdata", 32'(hostReadData), 32'h77);
    drain("t3_drain");
    chk("t3_nops", log_q.size(), 3);
    chk_op("t3_op0", 0, 1, 17'h00123, 8'h11);
    chk_op("t3_op1", 1, 1, 17'h00010, 8'h77);
    chk_op("t3_op2", 2, 0, 17'h00010, 8'h00);
    chk("t3_nvalid", valid_cnt - vbase, 1);

    // 5: reset while a write is outstanding with three queued behind it
    log_q.delete();
    vbase = valid_cnt;
    for (int i = 0; i < 4; i++) host_op(1, 0, 17'h00200 + 17'(i), 8'h30 + 8'(i));
    chk("t5_wreq_before", 32'(memoryWriteRequest), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_wreq_after", 32'(memoryWriteRequest), 0);
    chk("t5_rreq_after", 32'(memoryReadRequest), 0);
    chk("t5_busy_after", 32'(hostBusy), 0);
    chk("t5_ovf_after", 32'(hostOverflow), 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("t5_nops", log_q.size(), 1);
    chk("t5_no_valid", valid_cnt - vbase, 0);
    chk("t5_busy_late", 32'(hostBusy), 0);
    chk("t5_wreq_late", 32'(memoryWriteRequest), 0);

    // Randomized phase: reads return the last value written in program order
    log_q.delete();
    exp_w.delete();
    n_reads = 0;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      ra = RAND_BASE + 17'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        for (int i = 0; i < 200 && hostBusy; i++) @(negedge clock);
        chk("rnd_busy_wait", 32'(hostBusy), 0);
        rd = 8'($urandom);
        ref_mem[ra] = rd;
        exp_w.push_back('{w: 1, a: ra, d: rd});
        host_op(1, 0, ra, rd);
      end else begin
        exp_rd = ref_mem.exists(ra) ? ref_mem[ra] : 8'h00;
        vbase = valid_cnt;
        host_op(0, 1, ra, 8'h00);
        wait_valid(vbase, "rnd_valid");
        chk("rnd_rdata", 32'(hostReadData), 32'(exp_rd));
        n_reads++;
      end
    end
    drain("rnd_drain");
    wi = 0;
    seen_reads = 0;
    foreach (log_q[i]) begin
      if (log_q[i].w) begin
        if (wi < exp_w.size()) begin
          chk("rnd_w_addr", 32'(log_q[i].a), 32'(exp_w[wi].a));
          chk("rnd_w_data", 32'(log_q[i].d), 32'(exp_w[wi].d));
        end
        wi++;
      end else begin
        seen_reads++;
      end
    end
    chk("rnd_nwrites", wi, exp_w.size());
    chk("rnd_nreads", seen_reads, n_reads);
    chk("rnd_overflow", 32'(hostOverflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
